// File: rtl/axi_tlb_xlat_chan.sv
// Translation channel for one AXI address channel: forks each beat into an L1 lookup and
// an in-order payload buffer, then joins the buffered payload with the in-order result.
module axi_tlb_xlat_chan #(
    parameter int unsigned InpAddrWidth = 0,
    parameter int unsigned OupAddrWidth = 0,
    parameter int unsigned PayloadWidth = 1,
    parameter int unsigned Depth        = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [InpAddrWidth-1:0]      in_addr_i,
    input  logic [PayloadWidth-1:0]      in_payload_i,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    output logic [InpAddrWidth-1:0]      lookup_addr_o,
    output logic                         lookup_valid_o,
    input  logic                         lookup_ready_i,
    input  logic                         res_hit_i,
    input  logic [OupAddrWidth-1:0]      res_addr_i,
    input  logic                         res_valid_i,
    output logic                         res_ready_o,
    output logic [OupAddrWidth-1:0]      out_addr_o,
    output logic [PayloadWidth-1:0]      out_payload_o,
    output logic                         out_miss_o,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [$clog2(Depth+1)-1:0]   pending_o
);

    localparam int unsigned CntW = $clog2(Depth + 1);
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [PayloadWidth-1:0] buf_q [Depth];
    logic [PtrW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]         count_q, count_d;

    logic full, empty, push, pop;

    assign full  = (count_q == CntW'(Depth));
    assign empty = (count_q == '0);

    // Fork side: the lookup and the buffer entry are accepted together, so the
    // lookup handshake is the push condition.
    assign lookup_addr_o  = in_addr_i;
    assign lookup_valid_o = in_valid_i && !full;
    assign in_ready_o     = lookup_ready_i && !full;
    assign push           = in_valid_i && in_ready_o;

    // Join side: results come back in lookup order and pair with the head entry.
    assign out_valid_o   = !empty && res_valid_i;
    assign res_ready_o   = !empty && out_ready_i;
    assign pop           = out_valid_o && out_ready_i;
    assign out_addr_o    = res_hit_i ? res_addr_i : '0;
    assign out_miss_o    = !res_hit_i;
    assign out_payload_o = buf_q[rd_ptr_q];
    assign pending_o     = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + PtrW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CntW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage carries no reset; validity is tracked by the counter alone.
    always_ff @(posedge clk_i) begin
        if (push) begin
            buf_q[wr_ptr_q] <= in_payload_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(res_valid_i && empty))
                else $error("axi_tlb_xlat_chan: lookup result presented with no buffered beat");
        end
    end

endmodule

// File: tb/tb_axi_tlb_xlat_chan.sv
// Scoreboard bench for axi_tlb_xlat_chan: a small L1 model answers lookups in order and
// a monitor checks each output beat against the expected queue.
module tb_axi_tlb_xlat_chan;

    localparam int unsigned IW = 32;
    localparam int unsigned OW = 32;
    localparam int unsigned PW = 8;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic          hit;
        logic [OW-1:0] xa;
    } res_t;

    typedef struct packed {
        logic [OW-1:0] addr;
        logic          miss;
        logic [PW-1:0] pl;
    } exp_t;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [IW-1:0] in_addr_i;
    logic [PW-1:0] in_payload_i;
    logic          in_valid_i;
    logic          in_ready_o;
    logic [IW-1:0] lookup_addr_o;
    logic          lookup_valid_o;
    logic          lookup_ready_i;
    logic          res_hit_i;
    logic [OW-1:0] res_addr_i;
    logic          res_valid_i;
    logic          res_ready_o;
    logic [OW-1:0] out_addr_o;
    logic [PW-1:0] out_payload_o;
    logic          out_miss_o;
    logic          out_valid_o;
    logic          out_ready_i;
    logic [CW-1:0] pending_o;

    axi_tlb_xlat_chan #(
        .InpAddrWidth (IW),
        .OupAddrWidth (OW),
        .PayloadWidth (PW),
        .Depth        (DEPTH)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .in_addr_i      (in_addr_i),
        .in_payload_i   (in_payload_i),
        .in_valid_i     (in_valid_i),
        .in_ready_o     (in_ready_o),
        .lookup_addr_o  (lookup_addr_o),
        .lookup_valid_o (lookup_valid_o),
        .lookup_ready_i (lookup_ready_i),
        .res_hit_i      (res_hit_i),
        .res_addr_i     (res_addr_i),
        .res_valid_i    (res_valid_i),
        .res_ready_o    (res_ready_o),
        .out_addr_o     (out_addr_o),
        .out_payload_o  (out_payload_o),
        .out_miss_o     (out_miss_o),
        .out_valid_o    (out_valid_o),
        .out_ready_i    (out_ready_i),
        .pending_o      (pending_o)
    );

    always #5 clk_i = ~clk_i;

    res_t rq[$];
    exp_t exq[$];
    int   checks = 0;
    int   errors = 0;
    int   n_in   = 0;
    int   n_out  = 0;
    bit   rand_on = 1'b0;
    bit   res_stall = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic record(input logic [IW-1:0] a, input logic [PW-1:0] p,
                          input logic hit, input logic [OW-1:0] xa);
        res_t r;
        exp_t e;
        r.hit = hit;
        r.xa  = xa;
        e.addr = hit ? xa : '0;
        e.miss = !hit;
        e.pl   = p;
        rq.push_back(r);
        exq.push_back(e);
        n_in++;
        chk("lookup_addr", 64'(lookup_addr_o), 64'(a));
    endtask

    // Called in the phase just after a rising edge; returns in the same phase.
    task automatic send(input logic [IW-1:0] a, input logic [PW-1:0] p,
                        input logic hit, input logic [OW-1:0] xa);
        bit done = 1'b0;
        in_addr_i    = a;
        in_payload_i = p;
        in_valid_i   = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk_i);
            if (in_ready_o) begin
                record(a, p, hit, xa);
                done = 1'b1;
                break;
            end
        end
        if (!done) chk("send_timeout", 64'(0), 64'(1));
        step();
        in_valid_i = 1'b0;
    endtask

    task automatic drain(input int budget);
        bit done = 1'b0;
        for (int n = 0; n < budget; n++) begin
            step();
            if (exq.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) chk("drain_timeout", 64'(exq.size()), 64'(0));
        @(negedge clk_i);
        chk("pending_after_drain", 64'(pending_o), 64'(0));
        step();
    endtask

    // L1 model plus random back-pressure, driven just after each rising edge.
    always @(posedge clk_i) begin
        #1;
        if (rand_on) begin
            lookup_ready_i = ($urandom_range(0, 3) != 0);
            out_ready_i    = ($urandom_range(0, 2) != 0);
            res_stall      = ($urandom_range(0, 3) == 0);
        end else begin
            res_stall = 1'b0;
        end
        res_valid_i = (rq.size() > 0) && !res_stall;
        if (rq.size() > 0) begin
            res_hit_i  = rq[0].hit;
            res_addr_i = rq[0].xa;
        end
    end

    // Monitor: the handshake visible at the falling edge completes on the next rising edge.
    always @(negedge clk_i) begin
        if (!rst_i && res_valid_i && res_ready_o) begin
            if (rq.size() > 0) void'(rq.pop_front());
        end
        if (!rst_i && out_valid_o && out_ready_i) begin
            n_out++;
            if (exq.size() == 0) begin
                chk("unexpected_output", 64'(1), 64'(0));
            end else begin
                exp_t e;
                e = exq.pop_front();
                chk("out_addr", 64'(out_addr_o), 64'(e.addr));
                chk("out_miss", 64'(out_miss_o), 64'(e.miss));
                chk("out_payload", 64'(out_payload_o), 64'(e.pl));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_i          = 1'b1;
        in_valid_i     = 1'b0;
        in_addr_i      = '0;
        in_payload_i   = '0;
        lookup_ready_i = 1'b1;
        out_ready_i    = 1'b0;
        res_valid_i    = 1'b0;
        res_hit_i      = 1'b0;
        res_addr_i     = '0;
        step();
        step();
        @(negedge clk_i);
        chk("rst_pending", 64'(pending_o), 64'(0));
        chk("rst_out_valid", 64'(out_valid_o), 64'(0));
        chk("rst_res_ready", 64'(res_ready_o), 64'(0));
        chk("rst_in_ready", 64'(in_ready_o), 64'(1));
        step();
        rst_i       = 1'b0;
        out_ready_i = 1'b1;

        // single hit, then miss
        send(32'h1000_0040, 8'hA5, 1'b1, 32'h8000_0040);
        drain(50);
        send(32'h2000_1234, 8'h3C, 1'b0, 32'hDEAD_BEEF);
        drain(50);

        // fill: two accepted, third blocked until a pop has freed an entry
        out_ready_i = 1'b0;
        send(32'h3000_0000, 8'h01, 1'b1, 32'h7000_0000);
        send(32'h3000_1000, 8'h02, 1'b1, 32'h7000_1000);
        in_addr_i    = 32'h3000_2000;
        in_payload_i = 8'h03;
        in_valid_i   = 1'b1;
        @(negedge clk_i);
        chk("full_in_ready", 64'(in_ready_o), 64'(0));
        chk("full_pending", 64'(pending_o), 64'(2));
        chk("full_out_valid", 64'(out_valid_o), 64'(1));
        chk("stall_out_addr", 64'(out_addr_o), 64'(32'h7000_0000));
        chk("stall_out_payload", 64'(out_payload_o), 64'(8'h01));
        step();
        out_ready_i = 1'b1;
        @(negedge clk_i);
        chk("pop_full_in_ready", 64'(in_ready_o), 64'(0));
        step();
        out_ready_i = 1'b0;
        @(negedge clk_i);
        chk("after_pop_pending", 64'(pending_o), 64'(1));
        chk("after_pop_in_ready", 64'(in_ready_o), 64'(1));
        if (in_ready_o) record(32'h3000_2000, 8'h03, 1'b1, 32'h7000_2000);
        step();
        in_valid_i = 1'b0;
        @(negedge clk_i);
        chk("refill_pending", 64'(pending_o), 64'(2));
        step();
        out_ready_i = 1'b1;
        drain(50);

        // lookup back-pressure with space available
        lookup_ready_i = 1'b0;
        in_addr_i      = 32'h5000_0ABC;
        in_payload_i   = 8'h5A;
        in_valid_i     = 1'b1;
        @(negedge clk_i);
        chk("bp_in_ready", 64'(in_ready_o), 64'(0));
        chk("bp_lookup_valid", 64'(lookup_valid_o), 64'(1));
        step();
        @(negedge clk_i);
        chk("bp_pending", 64'(pending_o), 64'(0));
        step();
        lookup_ready_i = 1'b1;
        @(negedge clk_i);
        chk("bp_release_in_ready", 64'(in_ready_o), 64'(1));
        if (in_ready_o) record(32'h5000_0ABC, 8'h5A, 1'b1, 32'h6000_0ABC);
        step();
        in_valid_i = 1'b0;
        drain(50);

        // reset mid-stream
        out_ready_i = 1'b0;
        send(32'h1111_0000, 8'h77, 1'b1, 32'h2222_0000);
        send(32'h1111_1000, 8'h78, 1'b0, 32'h2222_1000);
        @(negedge clk_i);
        chk("pre_rst_pending", 64'(pending_o), 64'(2));
        step();
        rst_i = 1'b1;
        rq.delete();
        exq.delete();
        step();
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("post_rst_pending", 64'(pending_o), 64'(0));
        chk("post_rst_out_valid", 64'(out_valid_o), 64'(0));
        chk("post_rst_res_ready", 64'(res_ready_o), 64'(0));
        step();
        out_ready_i = 1'b1;
        send(32'h1234_5678, 8'h9E, 1'b1, 32'hABCD_E678);
        drain(50);

        // ordering under random stalls
        rand_on = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send(32'h4000_0000 + 32'(i) * 32'h1000, 8'(8'h10 + i), (i % 3) != 0,
                 32'h9000_0080 | (32'(i) << 12));
        end
        rand_on = 1'b0;
        step();
        lookup_ready_i = 1'b1;
        out_ready_i    = 1'b1;
        drain(500);
        chk("beats_out_vs_in", 64'(n_out), 64'(n_in - 2));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axi_tlb_xlat_chan.md
AXI_TLB_XLAT_CHAN -- requirements
Module: axi_tlb_xlat_chan

Interface
REQ-001 SHALL have parameter InpAddrWidth, default 0: input address width; must be > 12.
REQ-002 SHALL have parameter OupAddrWidth, default 0: output address width; must be > 12.
REQ-003 SHALL have parameter PayloadWidth, default 1: width of the opaque beat payload (ID, len, size, burst, user, ...).
REQ-004 SHALL have parameter Depth, default 2: maximum outstanding lookups; must be ≥ 1.
REQ-005 SHALL use one clock; reset is synchronous and active-high: clk_i, rst_i.
REQ-006 SHALL have these ports (name, direction, width, meaning):
- clk_i  in  1  rising-edge clock
- rst_i  in  1  synchronous reset, active-high
- in_addr_i  in  InpAddrWidth  untranslated beat address
- in_payload_i  in  PayloadWidth  beat payload
- in_valid_i  in  1  upstream beat valid
- in_ready_o  out  1  upstream beat ready
- lookup_addr_o  out  InpAddrWidth  lookup request address to the L1 channel
- lookup_valid_o  out  1  lookup request valid
- lookup_ready_i  in  1  lookup request ready
- res_hit_i  in  1  lookup result hit
- res_addr_i  in  OupAddrWidth  translated full address
- res_valid_i  in  1  result valid
- res_ready_o  out  1  result ready
- out_addr_o  out  OupAddrWidth  translated address
- out_payload_o  out  PayloadWidth  payload of the beat
- out_miss_o  out  1  translation missed
- out_valid_o  out  1  downstream beat valid
- out_ready_i  in  1  downstream beat ready
- pending_o  out  $clog2(Depth+1)  beats currently buffered

Function
REQ-007 SHALL fork each accepted upstream beat: one lookup request and one payload-buffer entry, in the same cycle.
REQ-008 SHALL drive lookup_valid_o = in_valid_i AND NOT full; lookup_addr_o = in_addr_i, passed through combinationally.
REQ-009 SHALL drive in_ready_o = lookup_ready_i AND NOT full.
REQ-010 SHALL push a beat (payload, in order) only on in_valid_i AND in_ready_o.
REQ-011 SHALL hold payloads in a circular buffer of Depth entries with write pointer, read pointer and counter; pointers wrap from Depth-1 to 0.
REQ-012 SHALL rely on results arriving in lookup order and pair the head buffer entry with the current result.
REQ-013 SHALL drive out_valid_o = NOT empty AND res_valid_i, and res_ready_o = NOT empty AND out_ready_i.
REQ-014 SHALL pop the head entry and consume the result on out_valid_o AND out_ready_i; zero-cycle latency from result to output.
REQ-015 SHALL drive on hit: out_addr_o = res_addr_i, out_miss_o = 0; on miss: out_addr_o = 0, out_miss_o = 1.
REQ-016 SHALL drive out_payload_o = head entry payload whenever not empty; value is don't-care when empty.
REQ-017 SHALL treat full (count == Depth) as blocking push even when a pop occurs the same cycle; no fall-through.
REQ-018 SHALL on a simultaneous push and pop when not full leave count unchanged and advance both pointers.
REQ-019 SHALL never accept res_valid_i while empty (res_ready_o = 0); a result arriving with the buffer empty is a protocol error, flagged by a simulation assertion.
REQ-020 SHALL drive pending_o = count.
REQ-021 SHALL keep out_* stable while out_valid_o AND NOT out_ready_i, provided res_* is held stable upstream.

Reset
REQ-022 SHALL on rst_i = 1 at a clock edge clear pointers and count: pending_o = 0, out_valid_o = 0, res_ready_o = 0, in_ready_o = lookup_ready_i.
REQ-023 SHALL on reset mid-operation discard buffered beats; the L1 channel shares rst_i, so no stale results remain.

Verification
REQ-024 SHALL cover single hit: in_addr 0x1000_0040 accepted, result hit/0x8000_0040 -> one out beat with addr 0x8000_0040, miss 0, original payload, pending back to 0.
REQ-025 SHALL cover miss: result hit = 0 -> out_addr 0, out_miss 1, payload intact.
REQ-026 SHALL cover fill with Depth = 2: out_ready_i = 0, three beats offered -> two accepted, in_ready_o = 0, pending_o = 2; a pop with a third beat still offered -> no push that cycle, push on the next.
REQ-027 SHALL cover ordering: 8 beats, random lookup/result/out stalls -> outputs in input order with matching payloads, and no loss or duplication.
REQ-028 SHALL cover lookup back-pressure: lookup_ready_i = 0 -> in_ready_o = 0 and no push although not full.
REQ-029 SHALL cover reset mid-stream: pending_o = 2, assert rst_i one cycle -> pending_o = 0, out_valid_o = 0; the next beat translates correctly.
